axis_pixel_packer: RTL and testbench

//  Upstream feeder for the TCB NN AXI-Stream top: accepts an 8-bit pixel byte stream,

---
 rtl/axis_pixel_packer_pkg.sv | 29 ++
 rtl/axis_pixel_packer.sv | 145 ++++++++++++++
 tb/tb_axis_pixel_packer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_pixel_packer_pkg.sv
// Shared AXIS framing constants and byte-lane helpers for the pixel packer.
package axis_pixel_packer_pkg;

    localparam int AXIS_DATA_W     = 32;
    localparam int BYTE_W          = 8;
    localparam int LANES           = 4;
    localparam int IMG_BYTES_MNIST = 784;

    // Byte slot index inside one packed word.
    typedef logic [1:0] lane_t;

    // One packed output beat: data plus end-of-image flag.
    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic                   last;
    } axis_word_t;

    // Merge a byte into slot 'lane' of a partially filled word (slot k -> bits [8k+7:8k]).
    function automatic logic [AXIS_DATA_W-1:0] place_byte(
        input logic [AXIS_DATA_W-1:0] word,
        input logic [BYTE_W-1:0]      b,
        input lane_t                  lane
    );
        logic [AXIS_DATA_W-1:0] shifted;
        shifted = {{(AXIS_DATA_W-BYTE_W){1'b0}}, b} << {lane, 3'b000};
        return word | shifted;
    endfunction

endpackage

// File: rtl/axis_pixel_packer.sv
// Packs an 8-bit pixel stream into 32-bit little-endian AXIS words and tags the
// final word of each image. Image end is whichever comes first: the fixed byte
// count or the source's own last marker. Any disagreement between the two sets
// a sticky len_err flag without disturbing the packing.
module axis_pixel_packer
    import axis_pixel_packer_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_W,
    parameter int IMG_BYTES  = IMG_BYTES_MNIST,
    parameter int CNT_W      = 16
) (
    input  logic                  axi_clk,
    input  logic                  axi_reset_n,
    input  logic                  s_axis_valid,
    input  logic [BYTE_W-1:0]     s_axis_data,
    input  logic                  s_axis_last,
    output logic                  s_axis_ready,
    output logic                  m_axis_valid,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_last,
    input  logic                  m_axis_ready,
    output logic                  len_err
);

    // Elaboration-time guards on parameter combinations the datapath cannot handle.
    if (DATA_WIDTH != LANES * BYTE_W) begin : g_bad_width
        $error("axis_pixel_packer: DATA_WIDTH must equal LANES*BYTE_W");
    end
    if ((64'd1 << CNT_W) <= 64'(IMG_BYTES)) begin : g_bad_cnt
        $error("axis_pixel_packer: CNT_W too narrow for IMG_BYTES");
    end

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_BYTES - 1);

    // Input-side state: current slot, bytes seen in this image, partial word.
    lane_t                 lane;
    logic [CNT_W-1:0]      byte_cnt;
    logic [DATA_WIDTH-1:0] acc;

    // Output register.
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    // Error tracking: source has used s_axis_last at least once since reset.
    logic                  last_in_use;
    logic                  err_flag;

    // Derived per-cycle controls.
    logic                  at_img_end;
    logic                  word_end;
    logic                  closes;
    logic                  accept;
    logic                  ready_int;
    logic [DATA_WIDTH-1:0] packed_word;

    // Decide whether the byte on the input closes a word and whether it can be taken.
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        at_img_end  = 1'b0;
        word_end    = 1'b0;
        closes      = 1'b0;
        ready_int   = 1'b0;
        accept      = 1'b0;
        packed_word = '0;

        at_img_end  = (byte_cnt == LAST_IDX);
        word_end    = at_img_end || s_axis_last;
        closes      = (lane == lane_t'(LANES - 1)) || word_end;
        // A closing byte needs a free output slot, or one that drains this very cycle.
        ready_int   = !closes || !out_valid || m_axis_ready;
        accept      = s_axis_valid && ready_int;
        packed_word = place_byte(acc, s_axis_data, lane);
    end

    // Accumulator and lane: slot the accepted byte in, restart empty after a close.
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            lane <= '0;
            acc  <= '0;
        end else if (accept) begin
            if (closes) begin
                lane <= '0;
                acc  <= '0;
            end else begin
                lane <= lane + lane_t'(1);
                acc  <= packed_word;
            end
        end
    end

    // Image byte counter: wraps to zero on whichever image end arrives first.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            byte_cnt <= '0;
        end else if (accept) begin
            if (word_end) begin
                byte_cnt <= '0;
            end else begin
                byte_cnt <= byte_cnt + CNT_W'(1);
            end
        end
    end

    // Output register: load on close, hold while stalled, empty after a plain drain.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (accept && closes) begin
            out_valid <= 1'b1;
            out_data  <= packed_word;
            out_last  <= word_end;
        end else if (m_axis_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Length checker: flag an early source last, or a missing one once the source uses it.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            last_in_use <= 1'b0;
            err_flag    <= 1'b0;
        end else if (accept) begin
            if (s_axis_last) begin
                last_in_use <= 1'b1;
            end
            if (s_axis_last && !at_img_end) begin
                err_flag <= 1'b1;
            end
            if (at_img_end && !s_axis_last && last_in_use) begin
                err_flag <= 1'b1;
            end
        end
    end

    assign s_axis_ready = ready_int;
    assign m_axis_valid = out_valid;
    assign m_axis_data  = out_data;
    assign m_axis_last  = out_last;
    assign len_err      = err_flag;

endmodule

// File: tb/tb_axis_pixel_packer.sv
// Scoreboard bench for axis_pixel_packer: three instances with different image sizes,
// expected words queued as bytes are driven and compared as words leave the DUT.
module tb_axis_pixel_packer;

    localparam int N_DUT = 3;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic       axi_clk = 1'b0;
    logic       axi_reset_n;
    logic       s_valid [N_DUT];
    logic [7:0] s_data  [N_DUT];
    logic       s_last  [N_DUT];
    logic       s_ready [N_DUT];
    logic       m_valid [N_DUT];
    logic [31:0] m_data [N_DUT];
    logic       m_last  [N_DUT];
    logic       m_ready [N_DUT];
    logic       len_err [N_DUT];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   active   = 0;
    exp_t exp_q [$];
    int   hs_cyc [$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    always #5 axi_clk = ~axi_clk;

    always @(posedge axi_clk) cyc <= cyc + 1;

    // Instance 0: 8-byte images, 1: 6-byte images, 2: 128-byte images.
    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int IB = (g == 0) ? 8 : (g == 1) ? 6 : 128;
        axis_pixel_packer #(
            .DATA_WIDTH(32),
            .IMG_BYTES (IB),
            .CNT_W     (16)
        ) dut (
            .axi_clk     (axi_clk),
            .axi_reset_n (axi_reset_n),
            .s_axis_valid(s_valid[g]),
            .s_axis_data (s_data[g]),
            .s_axis_last (s_last[g]),
            .s_axis_ready(s_ready[g]),
            .m_axis_valid(m_valid[g]),
            .m_axis_data (m_data[g]),
            .m_axis_last (m_last[g]),
            .m_axis_ready(m_ready[g]),
            .len_err     (len_err[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance n cycles, leaving inputs settled just after the rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge axi_clk);
            #1;
        end
    endtask

    // Present one byte and hold it until accepted; returns just after the accepting edge.
    task automatic send_byte(input int d, input logic [7:0] b, input logic l);
        int budget;
        budget     = 200;
        s_valid[d] = 1'b1;
        s_data[d]  = b;
        s_last[d]  = l;
        forever begin
            @(negedge axi_clk);
            if (s_ready[d]) break;
            budget--;
            if (budget == 0) begin
                check("s_ready_wait", 32'(s_ready[d]), 32'd1);
                break;
            end
        end
        @(posedge axi_clk);
        #1;
        s_valid[d] = 1'b0;
        s_last[d]  = 1'b0;
    endtask

    // Wait until every queued expectation has been matched.
    task automatic wait_drain();
        int budget;
        budget = 400;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge axi_clk);
            budget--;
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        idle(1);
    endtask

    // Output monitor: hold-stability while stalled, scoreboard compare on handshake.
    always @(negedge axi_clk) begin
        if (!axi_reset_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(m_valid[active]), 32'd1);
                check("hold_data", m_data[active], prev_data);
                check("hold_last", 32'(m_last[active]), 32'(prev_last));
            end
            if (m_valid[active] && m_ready[active]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(m_valid[active]), 32'd0);
                end else begin
                    check("word_data", m_data[active], exp_q[0].data);
                    check("word_last", 32'(m_last[active]), 32'(exp_q[0].last));
                    void'(exp_q.pop_front());
                    hs_cyc.push_back(cyc);
                end
            end
            prev_stall <= m_valid[active] && !m_ready[active];
            prev_data  <= m_data[active];
            prev_last  <= m_last[active];
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] word;
        logic [7:0]  b;
        bit          rnd_done;
        int          c0;

        axi_reset_n = 1'b0;
        for (int d = 0; d < N_DUT; d++) begin
            s_valid[d] = 1'b0;
            s_data[d]  = '0;
            s_last[d]  = 1'b0;
            m_ready[d] = 1'b1;
        end

        // Reset state.
        #7;
        check("rst_m_valid", 32'(m_valid[0]), 32'd0);
        check("rst_m_data", m_data[0], 32'd0);
        check("rst_m_last", 32'(m_last[0]), 32'd0);
        check("rst_len_err", 32'(len_err[0]), 32'd0);
        idle(2);
        axi_reset_n = 1'b1;
        idle(2);

        // Test 1: 8-byte image back-to-back, full throughput.
        active = 0;
        hs_cyc.delete();
        exp_q.push_back('{data: 32'h04030201, last: 1'b0});
        exp_q.push_back('{data: 32'h08070605, last: 1'b1});
        c0 = cyc;
        for (int i = 1; i <= 8; i++) send_byte(0, 8'(i), 1'b0);
        check("t1_byte_cycles", 32'(cyc - c0), 32'd8);
        wait_drain();
        check("t1_word_count", 32'(hs_cyc.size()), 32'd2);
        if (hs_cyc.size() == 2) check("t1_word_spacing", 32'(hs_cyc[1] - hs_cyc[0]), 32'd4);
        check("t1_len_err", 32'(len_err[0]), 32'd0);

        // Test 2: 6-byte image, zero-padded tail, next image restarts at lane 0.
        active = 1;
        exp_q.push_back('{data: 32'hA3A2A1A0, last: 1'b0});
        exp_q.push_back('{data: 32'h0000A5A4, last: 1'b1});
        for (int i = 0; i < 6; i++) send_byte(1, 8'hA0 + 8'(i), 1'b0);
        exp_q.push_back('{data: 32'hB3B2B1B0, last: 1'b0});
        exp_q.push_back('{data: 32'h0000B5B4, last: 1'b1});
        for (int i = 0; i < 6; i++) send_byte(1, 8'hB0 + 8'(i), 1'b0);
        wait_drain();
        check("t2_len_err", 32'(len_err[1]), 32'd0);

        // Test 3: downstream stalls 10 cycles after the first word appears.
        active = 0;
        m_ready[0] = 1'b0;
        exp_q.push_back('{data: 32'h34333231, last: 1'b0});
        exp_q.push_back('{data: 32'h38373635, last: 1'b1});
        fork
            begin
                for (int i = 1; i <= 8; i++) send_byte(0, 8'h30 + 8'(i), 1'b0);
            end
            begin
                int budget;
                budget = 50;
                do begin
                    @(negedge axi_clk);
                    budget--;
                end while (!m_valid[0] && budget > 0);
                check("t3_first_word_seen", 32'(m_valid[0]), 32'd1);
                repeat (3) @(negedge axi_clk);
                check("t3_byte4_presented", 32'(s_data[0]), 32'h38);
                check("t3_s_ready_low", 32'(s_ready[0]), 32'd0);
                repeat (7) @(posedge axi_clk);
                #1;
                m_ready[0] = 1'b1;
            end
        join
        wait_drain();
        check("t3_len_err", 32'(len_err[0]), 32'd0);

        // Test 4: early source last on byte 3, then a full image to show the counter restarted.
        exp_q.push_back('{data: 32'h00332211, last: 1'b1});
        send_byte(0, 8'h11, 1'b0);
        send_byte(0, 8'h22, 1'b0);
        send_byte(0, 8'h33, 1'b1);
        wait_drain();
        check("t4_len_err", 32'(len_err[0]), 32'd1);
        exp_q.push_back('{data: 32'hC4C3C2C1, last: 1'b0});
        exp_q.push_back('{data: 32'hC8C7C6C5, last: 1'b1});
        for (int i = 1; i <= 8; i++) send_byte(0, 8'hC0 + 8'(i), 1'b0);
        wait_drain();

        // Test 5: 128-byte image with random source gaps and random downstream ready.
        active = 2;
        rnd_done = 1'b0;
        fork
            begin
                for (int w = 0; w < 32; w++) begin
                    word = '0;
                    for (int k = 0; k < 4; k++) begin
                        b = 8'($urandom);
                        word[8*k +: 8] = b;
                        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                        if (k == 0) exp_q.push_back('{data: 32'h0, last: 1'b0});
                        send_byte(2, b, 1'b0);
                    end
                    exp_q[exp_q.size() - 1] = '{data: word, last: (w == 31)};
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge axi_clk);
                    #1;
                    m_ready[2] = 1'($urandom_range(0, 1));
                end
                m_ready[2] = 1'b1;
            end
        join
        wait_drain();
        check("t5_len_err", 32'(len_err[2]), 32'd0);

        // Test 6: reset with a stalled word and a half-built word, then a clean word.
        active = 0;
        m_ready[0] = 1'b0;
        for (int i = 1; i <= 4; i++) send_byte(0, 8'h40 + 8'(i), 1'b0);
        send_byte(0, 8'h61, 1'b0);
        send_byte(0, 8'h62, 1'b0);
        check("t6_pending_valid", 32'(m_valid[0]), 32'd1);
        check("t6_err_before_rst", 32'(len_err[0]), 32'd1);
        @(posedge axi_clk);
        #3;
        axi_reset_n = 1'b0;
        #1;
        check("t6_rst_m_valid", 32'(m_valid[0]), 32'd0);
        check("t6_rst_m_data", m_data[0], 32'd0);
        check("t6_rst_m_last", 32'(m_last[0]), 32'd0);
        check("t6_rst_len_err", 32'(len_err[0]), 32'd0);
        idle(2);
        axi_reset_n = 1'b1;
        m_ready[0] = 1'b1;
        idle(1);
        exp_q.push_back('{data: 32'h58575655, last: 1'b0});
        for (int i = 0; i < 4; i++) send_byte(0, 8'h55 + 8'(i), 1'b0);
        wait_drain();
        check("t6_len_err_after", 32'(len_err[0]), 32'd0);

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
